// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, FSM states,
// byte-lane mask and load-extension helpers.
// Optional feature macro: MISALIGN_SPLIT_EN (adds the SPLIT state).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP
`ifdef MISALIGN_SPLIT_EN
    ,
    ST_SPLIT
`endif
  } state_e;

  // Contiguous byte pattern of the access size, before lane positioning.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Byte enables of an aligned access within one word.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Sign/zero extension of right-aligned load data.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (f3)
      F3_B:    load_ext = 32'(b);
      F3_H:    load_ext = 32'(h);
      F3_BU:   load_ext = {24'd0, d[7:0]};
      F3_HU:   load_ext = {16'd0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data RAM: MEM_SIZE x 32 bits, four byte-lane write enables,
// combinational read, contents zero at time 0 and untouched by reset.
module dmem_bank #(
  parameter int MEM_SIZE = 64,
  parameter int IDX_W    = $clog2(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_SIZE] = '{default: '0};

  // Byte-lane write; lanes without an enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of the data RAM: valid/ready request and
// response channels, 1-cycle registered read, byte/half/word steering and
// error responses. Optional macro MISALIGN_SPLIT_EN splits misaligned H/W
// accesses into two word beats instead of reporting an error.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int WRAP_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  state_e                  state_q, state_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    accept;
  logic [1:0]              lane;
  logic [IDX_W-1:0]        req_idx;
  logic [ADDR_WIDTH-1:0]   word_full;
  logic                    f3_ok, misal, oor, req_err;
  logic [3:0]              be_lo;
  logic [31:0]             wd_lo;
  logic [31:0]             rd_word, rd_shift;

  logic                    bank_we;
  logic [3:0]              bank_be;
  logic [IDX_W-1:0]        bank_idx;
  logic [31:0]             bank_wdata;

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign lane      = req_addr[1:0];
  assign req_idx   = req_addr[IDX_W+1:2];
  assign word_full = {2'b00, req_addr[ADDR_WIDTH-1:2]};

  assign f3_ok = req_we ? (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W)
                        : (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                           req_funct3 == F3_BU || req_funct3 == F3_HU);
  assign misal = f3_ok && (((req_funct3[1:0] == 2'b01) && lane[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (lane != 2'b00)));
  assign oor   = (WRAP_ADDR == 0) && (word_full >= ADDR_WIDTH'(MEM_SIZE));

  assign be_lo    = lane_mask(req_funct3, lane);
  assign wd_lo    = req_wdata << {lane, 3'b000};
  assign rd_shift = rd_word >> {lane, 3'b000};

`ifdef MISALIGN_SPLIT_EN
  logic                    oor_hi;
  logic [7:0]              be_span;
  logic [63:0]             wd_span;
  logic [31:0]             split_merge;
  logic [IDX_W-1:0]        split_idx_q, split_idx_d;
  logic                    split_we_q, split_we_d;
  logic [2:0]              split_f3_q, split_f3_d;
  logic [1:0]              split_lane_q, split_lane_d;
  logic [31:0]             split_lo_q, split_lo_d;
  logic [3:0]              split_be_q, split_be_d;
  logic [31:0]             split_wdata_q, split_wdata_d;

  // Second word would fall outside the RAM when wrapping is disabled.
  assign oor_hi      = misal && (WRAP_ADDR == 0) && (word_full >= ADDR_WIDTH'(MEM_SIZE - 1));
  assign req_err     = !f3_ok || oor || oor_hi;
  assign be_span     = {4'b0000, size_mask(req_funct3)} << lane;
  assign wd_span     = {32'd0, req_wdata} << {lane, 3'b000};
  assign split_merge = 32'({rd_word, split_lo_q} >> {split_lane_q, 3'b000});
`else
  assign req_err = !f3_ok || misal || oor;
`endif

  dmem_bank #(
    .MEM_SIZE (MEM_SIZE),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (bank_be),
    .idx   (bank_idx),
    .wdata (bank_wdata),
    .rdata (rd_word)
  );

  // Next-state, RAM port steering and response capture.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bank_we     = 1'b0;
    bank_be     = 4'b0000;
    bank_idx    = req_idx;
    bank_wdata  = wd_lo;
`ifdef MISALIGN_SPLIT_EN
    split_idx_d   = split_idx_q;
    split_we_d    = split_we_q;
    split_f3_d    = split_f3_q;
    split_lane_d  = split_lane_q;
    split_lo_d    = split_lo_q;
    split_be_d    = split_be_q;
    split_wdata_d = split_wdata_q;
`endif
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = ST_RESP;
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end
`ifdef MISALIGN_SPLIT_EN
          else if (misal) begin
            // First beat on this edge, second beat from the SPLIT state.
            state_d       = ST_SPLIT;
            rsp_err_d     = 1'b0;
            rsp_rdata_d   = 32'd0;
            bank_we       = req_we;
            bank_be       = be_span[3:0];
            bank_wdata    = wd_span[31:0];
            split_idx_d   = req_idx + IDX_W'(1);
            split_we_d    = req_we;
            split_f3_d    = req_funct3;
            split_lane_d  = lane;
            split_lo_d    = rd_word;
            split_be_d    = be_span[7:4];
            split_wdata_d = wd_span[63:32];
          end
`endif
          else begin
            rsp_err_d   = 1'b0;
            bank_we     = req_we;
            bank_be     = be_lo;
            rsp_rdata_d = req_we ? 32'd0 : load_ext(req_funct3, rd_shift);
          end
        end else if ((state_q == ST_RESP) && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ST_SPLIT: begin
        state_d     = ST_RESP;
        bank_idx    = split_idx_q;
        bank_we     = split_we_q;
        bank_be     = split_be_q;
        bank_wdata  = split_wdata_q;
        rsp_rdata_d = split_we_q ? 32'd0 : load_ext(split_f3_q, split_merge);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and response registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef MISALIGN_SPLIT_EN
  // Second-beat context; only meaningful while in SPLIT, so left unreset.
  always_ff @(posedge clk) begin
    split_idx_q   <= split_idx_d;
    split_we_q    <= split_we_d;
    split_f3_q    <= split_f3_d;
    split_lane_q  <= split_lane_d;
    split_lo_q    <= split_lo_d;
    split_be_q    <= split_be_d;
    split_wdata_q <= split_wdata_d;
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu: a wrapping and a non-wrapping instance
// share one request stream; expected values are hand-computed.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        nw_req_ready, nw_rsp_valid, nw_rsp_err;
  logic [31:0] nw_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_nw_rd;
  logic        last_nw_err;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WIDTH(32), .MEM_SIZE(64), .WRAP_ADDR(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_lsu #(.ADDR_WIDTH(32), .MEM_SIZE(64), .WRAP_ADDR(0)) u_dut_nw (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(nw_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(nw_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(nw_rsp_rdata), .rsp_err(nw_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request with rsp_ready held high; returns the wrapping DUT's response.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      output logic [31:0] rd, output logic err);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    rd          = rsp_rdata;
    err         = rsp_err;
    last_nw_rd  = nw_rsp_rdata;
    last_nw_err = nw_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    xact(tag, we, f3, addr, wd, exp_lat, rd, err);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);

    // Word store then load back.
    run("sw_08",  1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    run("lw_08",  1'b0, 3'b010, 32'h08, 32'h0,        1, 32'hDEADBEEF, 1'b0);

    // Byte store into lane 3, then the narrow loads.
    run("sb_0b",  1'b1, 3'b000, 32'h0B, 32'h00000080, 1, 32'h0, 1'b0);
    run("lw_08b", 1'b0, 3'b010, 32'h08, 32'h0,        1, 32'h80ADBEEF, 1'b0);
    run("lb_0b",  1'b0, 3'b000, 32'h0B, 32'h0,        1, 32'hFFFFFF80, 1'b0);
    run("lbu_0b", 1'b0, 3'b100, 32'h0B, 32'h0,        1, 32'h00000080, 1'b0);
    run("lh_0a",  1'b0, 3'b001, 32'h0A, 32'h0,        1, 32'hFFFF80AD, 1'b0);
    run("lhu_08", 1'b0, 3'b101, 32'h08, 32'h0,        1, 32'h0000BEEF, 1'b0);
    run("lb_09",  1'b0, 3'b000, 32'h09, 32'h0,        1, 32'hFFFFFFBE, 1'b0);

    // Invalid funct3 codes.
    run("ld_f3_011", 1'b0, 3'b011, 32'h08, 32'h0, 1, 32'h0, 1'b1);
    run("st_f3_100", 1'b1, 3'b100, 32'h08, 32'h0, 1, 32'h0, 1'b1);
    run("lw_08_c",   1'b0, 3'b010, 32'h08, 32'h0, 1, 32'h80ADBEEF, 1'b0);

`ifdef MISALIGN_SPLIT_EN
    // Misaligned word straddling words 3 and 4.
    run("sw_0e_split", 1'b1, 3'b010, 32'h0E, 32'h11223344, 2, 32'h0, 1'b0);
    run("lw_0e_split", 1'b0, 3'b010, 32'h0E, 32'h0,        2, 32'h11223344, 1'b0);
    run("lbu_0e",      1'b0, 3'b100, 32'h0E, 32'h0,        1, 32'h00000044, 1'b0);
    run("lbu_0f",      1'b0, 3'b100, 32'h0F, 32'h0,        1, 32'h00000033, 1'b0);
    run("lbu_10",      1'b0, 3'b100, 32'h10, 32'h0,        1, 32'h00000022, 1'b0);
    run("lbu_11",      1'b0, 3'b100, 32'h11, 32'h0,        1, 32'h00000011, 1'b0);
    run("lh_0f_split", 1'b0, 3'b001, 32'h0F, 32'h0,        2, 32'h00002233, 1'b0);
`else
    // Misaligned accesses error without touching memory.
    run("lw_0a_mis", 1'b0, 3'b010, 32'h0A, 32'h0, 1, 32'h0, 1'b1);
    run("sw_0a_mis", 1'b1, 3'b010, 32'h0A, 32'h0, 1, 32'h0, 1'b1);
    run("lh_09_mis", 1'b0, 3'b001, 32'h09, 32'h0, 1, 32'h0, 1'b1);
    run("lw_08_mis", 1'b0, 3'b010, 32'h08, 32'h0, 1, 32'h80ADBEEF, 1'b0);
`endif

    // Back-pressure: response held while a new request waits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_funct3 = 3'b100; req_addr = 32'h0B;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_next_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_rdata", rsp_rdata, 32'h00000080);
    @(posedge clk); #1;
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Address wrap versus range error.
    begin
      logic [31:0] rd;
      logic        err;
      xact("sw_100", 1'b1, 3'b010, 32'h100, 32'h5A5A5A5A, 1, rd, err);
      check("sw_100_err_wrap", 32'(err), 32'd0);
      check("sw_100_err_nowrap", 32'(last_nw_err), 32'd1);
      check("sw_100_rdata_nowrap", last_nw_rd, 32'd0);
      xact("lw_000", 1'b0, 3'b010, 32'h000, 32'h0, 1, rd, err);
      check("lw_000_wrap", rd, 32'h5A5A5A5A);
      check("lw_000_nowrap", last_nw_rd, 32'h0);
      check("lw_000_nowrap_err", 32'(last_nw_err), 32'd0);
    end

    // Reset in the middle of a pending response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_err", 32'(rsp_err), 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    check("rst_mid_nw_valid", 32'(nw_rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_nw_req_ready", 32'(nw_req_ready), 32'd1);
    run("lw_08_post_rst", 1'b0, 3'b010, 32'h08, 32'h0, 1, 32'h80ADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
